// File: rtl/mul_sequencer_if.sv
// Interface bundling the execute-stage operand, ALU and writeback signals of the multiply sequencer.
// slave is the sequencer side; master is the pipeline/ALU side.
interface mul_sequencer_if #(
  parameter int N = 64
);
  logic         start;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic [N-1:0] srcA_in;
  logic [N-1:0] srcB_in;
  logic [3:0]   aluctrl_in;
  logic [N-1:0] alu_result;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_ctrl;
  logic         stall;
  logic         done;
  logic [N-1:0] product;

  modport slave (
    input  start, multiplicand, multiplier, srcA_in, srcB_in, aluctrl_in, alu_result,
    output alu_a, alu_b, alu_ctrl, stall, done, product
  );

  modport master (
    output start, multiplicand, multiplier, srcA_in, srcB_in, aluctrl_in, alu_result,
    input  alu_a, alu_b, alu_ctrl, stall, done, product
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add MUL controller that borrows the execute-stage ALU as its accumulator adder.
// Passes pipeline operands through when idle; stalls the pipeline while a multiply runs.
module mul_sequencer #(
  parameter int         N        = 64,
  parameter logic [3:0] ADD_CTRL = 4'b0010
) (
  input  logic          clk,
  input  logic          reset,
  mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  mcand_r, mplier_r, acc_r, product_r;
  logic [CW-1:0] cnt;
  logic          last_iter;
  logic          mplier_zero;

  logic [N-1:0]  alu_a_c, alu_b_c;
  logic [3:0]    alu_ctrl_c;
  logic          stall_c, done_c;

  assign last_iter   = (cnt == CW'(N - 1));
  assign mplier_zero = (mplier_r == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mcand_r   <= '0;
      mplier_r  <= '0;
      acc_r     <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand_r  <= bus.multiplicand;
            mplier_r <= bus.multiplier;
            acc_r    <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (mplier_zero) begin
            product_r <= acc_r;
          end else begin
            acc_r    <= bus.alu_result;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt      <= cnt + CW'(1);
            // On the final iteration the ALU sum is the product; acc_r is one step behind.
            if (last_iter) product_r <= bus.alu_result;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    alu_a_c    = bus.srcA_in;
    alu_b_c    = bus.srcB_in;
    alu_ctrl_c = bus.aluctrl_in;
    stall_c    = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stall_c   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        stall_c    = 1'b1;
        alu_a_c    = acc_r;
        alu_b_c    = mplier_r[0] ? mcand_r : '0;
        alu_ctrl_c = ADD_CTRL;
        if (mplier_zero || last_iter) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.alu_a    = alu_a_c;
  assign bus.alu_b    = alu_b_c;
  assign bus.alu_ctrl = alu_ctrl_c;
  assign bus.stall    = stall_c;
  assign bus.done     = done_c;
  assign bus.product  = product_r;
endmodule
